// File: rtl/display_share_arbiter.sv
// Round-robin owner selection for the shared 8-digit display word, with a minimum dwell per owner.
// Latency: req -> grant/disp_data 1 cycle from idle; owner data_in -> disp_data 1 cycle.
// No backpressure: requesters hold req level until they see grant; define DISP_ARB_PREEMPT0_EN for urgent requester 0.
module display_share_arbiter #(
  parameter int                NUM_REQ      = 4,
  parameter int                DATA_W       = 32,
  parameter int                DWELL_CYCLES = 50_000_000,
  parameter logic [DATA_W-1:0] BLANK_WORD   = {DATA_W{1'b1}}
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_W-1:0]    data_in,
  output logic [NUM_REQ-1:0]           grant,
  output logic [DATA_W-1:0]            disp_data,
  output logic                         disp_valid,
  output logic [$clog2(NUM_REQ)-1:0]   owner_id,
  output logic                         switch_pulse
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] SAT = CNT_W'(DWELL_CYCLES - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state, n_state;
  logic [ID_W-1:0]   ptr, n_ptr, n_owner;
  logic [CNT_W-1:0]  cnt, n_cnt;
  logic              n_valid, n_pulse;
  logic [DATA_W-1:0] n_data;
  logic [NUM_REQ-1:0] n_grant;
  logic              idle_hit, hold_hit;
  logic [ID_W-1:0]   idle_idx, hold_idx, idle_k, hold_k;
  logic [DATA_W-1:0] idle_word, owner_word, hold_word;

  // Select one requester's word out of the flat data bus.
  function automatic logic [DATA_W-1:0] word_at(input logic [ID_W-1:0] k,
                                                 input logic [NUM_REQ*DATA_W-1:0] bus);
    logic [DATA_W-1:0] w;
    w = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (k == ID_W'(j)) w = bus[j*DATA_W +: DATA_W];
    end
    return w;
  endfunction

  // Round-robin searches: from idle start after the pointer (pointer itself last);
  // from hold start after the owner and never land on the owner itself.
  always_comb begin
    idle_hit = 1'b0;
    idle_idx = ptr;
    idle_k   = '0;
    hold_hit = 1'b0;
    hold_idx = owner_id;
    hold_k   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idle_k = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!idle_hit && req[idle_k]) begin
        idle_hit = 1'b1;
        idle_idx = idle_k;
      end
    end
    for (int i = 1; i < NUM_REQ; i++) begin
      hold_k = ID_W'((int'(owner_id) + i) % NUM_REQ);
      if (!hold_hit && req[hold_k]) begin
        hold_hit = 1'b1;
        hold_idx = hold_k;
      end
    end
    idle_word  = word_at(idle_idx, data_in);
    owner_word = word_at(owner_id, data_in);
    hold_word  = word_at(hold_idx, data_in);
  end

  // Next-state and next-output decision; release always wins over dwell expiry.
  always_comb begin
    n_state = state;
    n_owner = owner_id;
    n_ptr   = ptr;
    n_cnt   = cnt;
    n_valid = disp_valid;
    n_pulse = 1'b0;
    n_data  = disp_data;
    n_grant = '0;
    case (state)
      IDLE: begin
        n_valid = 1'b0;
        n_data  = BLANK_WORD;
        if (idle_hit) begin
          n_state = HOLD;
          n_owner = idle_idx;
          n_ptr   = idle_idx;
          n_cnt   = '0;
          n_valid = 1'b1;
          n_pulse = 1'b1;
          n_data  = idle_word;
        end
      end
      HOLD: begin
        n_cnt  = (cnt == SAT) ? cnt : cnt + 1'b1;
        n_data = owner_word;
        if (!req[owner_id]) begin
          n_state = IDLE;
          n_cnt   = '0;
          n_valid = 1'b0;
          n_pulse = 1'b1;
          n_data  = BLANK_WORD;
        end
`ifdef DISP_ARB_PREEMPT0_EN
        else if (req[0] && owner_id != '0) begin
          n_owner = '0;
          n_ptr   = '0;
          n_cnt   = '0;
          n_pulse = 1'b1;
          n_data  = data_in[DATA_W-1:0];
        end else if (owner_id != '0 && cnt == SAT && hold_hit) begin
`else
        else if (cnt == SAT && hold_hit) begin
`endif
          n_owner = hold_idx;
          n_ptr   = hold_idx;
          n_cnt   = '0;
          n_pulse = 1'b1;
          n_data  = hold_word;
        end
      end
      default: n_state = IDLE;
    endcase
    if (n_valid) n_grant[n_owner] = 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= n_state;
  end

  // Registered outputs, dwell counter and round-robin pointer.
  always_ff @(posedge clock) begin
    if (!reset) begin
      grant        <= '0;
      disp_data    <= BLANK_WORD;
      disp_valid   <= 1'b0;
      owner_id     <= '0;
      switch_pulse <= 1'b0;
      cnt          <= '0;
      ptr          <= ID_W'(NUM_REQ - 1);
    end else begin
      grant        <= n_grant;
      disp_data    <= n_data;
      disp_valid   <= n_valid;
      owner_id     <= n_owner;
      switch_pulse <= n_pulse;
      cnt          <= n_cnt;
      ptr          <= n_ptr;
    end
  end

endmodule

// File: tb/tb_display_share_arbiter.sv
`timescale 1ns/1ps
// Bench for display_share_arbiter: directed scenarios plus random traffic,
// checked every cycle against an owner/age reference model.
module tb_display_share_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int DWELL   = 4;
  localparam logic [31:0] BLANK = 32'hFFFF_FFFF;

  logic         clock = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [127:0] data_in;
  logic [3:0]   grant;
  logic [31:0]  disp_data;
  logic         disp_valid;
  logic [1:0]   owner_id;
  logic         switch_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owner index (-1 when idle), last owner, rr pointer,
  // number of cycles the current owner has held the display.
  int          m_owner, m_last, m_ptr, m_age;
  logic        m_pulse;
  logic [31:0] m_data;

  always #5 clock = ~clock;

  display_share_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .DWELL_CYCLES(DWELL), .BLANK_WORD(BLANK)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .data_in(data_in),
    .grant(grant), .disp_data(disp_data), .disp_valid(disp_valid),
    .owner_id(owner_id), .switch_pulse(switch_pulse)
  );

  function automatic logic [31:0] word_of(int i);
    return data_in[i*32 +: 32];
  endfunction

  // First requesting index after base (wrapping), excluding skip; -1 if none.
  function automatic int find_next(int base, int skip);
    for (int i = 1; i <= NUM_REQ; i++) begin
      int k = (base + i) % NUM_REQ;
      if (k != skip && req[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_step();
    int nxt;
    m_pulse = 1'b0;
    if (!reset) begin
      m_owner = -1; m_last = 0; m_ptr = NUM_REQ - 1; m_age = 0; m_data = BLANK;
    end else if (m_owner < 0) begin
      nxt = find_next(m_ptr, -1);
      if (nxt >= 0) begin
        m_owner = nxt; m_last = nxt; m_ptr = nxt; m_age = 1; m_pulse = 1'b1;
        m_data = word_of(nxt);
      end else begin
        m_data = BLANK;
      end
    end else if (!req[m_owner]) begin
      m_owner = -1; m_age = 0; m_pulse = 1'b1; m_data = BLANK;
    end else begin
      nxt = (m_age >= DWELL) ? find_next(m_owner, m_owner) : -1;
      if (nxt >= 0) begin
        m_owner = nxt; m_last = nxt; m_ptr = nxt; m_age = 1; m_pulse = 1'b1;
        m_data = word_of(nxt);
      end else begin
        m_age++;
        m_data = word_of(m_owner);
      end
    end
  endtask

  task automatic check_one(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_model(string tag);
    logic [3:0] eg;
    eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    check_one({tag, ".grant"},  {28'b0, grant}, {28'b0, eg});
    check_one({tag, ".data"},   disp_data, m_data);
    check_one({tag, ".valid"},  {31'b0, disp_valid}, {31'b0, (m_owner >= 0)});
    check_one({tag, ".owner"},  {30'b0, owner_id}, 32'(m_last));
    check_one({tag, ".pulse"},  {31'b0, switch_pulse}, {31'b0, m_pulse});
    check_one({tag, ".onehot0"}, {31'b0, $onehot0(grant)}, 32'd1);
  endtask

  task automatic tick(string tag);
    model_step();
    @(posedge clock);
    #1;
    check_model(tag);
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    req   = 4'b0000;
    repeat (3) tick("rst");
    reset = 1'b1;
  endtask

  initial begin
    reset   = 1'b0;
    req     = 4'b0000;
    data_in = '0;

    // Reset and single requester
    reset_dut();
    tick("idle");
    check_one("idle_grant", {28'b0, grant}, 32'h0);
    check_one("idle_data", disp_data, 32'hFFFF_FFFF);
    check_one("idle_valid", {31'b0, disp_valid}, 32'h0);
    data_in[31:0] = 32'h0000_1234;
    req = 4'b0001;
    tick("single");
    check_one("single_grant", {28'b0, grant}, 32'h1);
    check_one("single_data", disp_data, 32'h0000_1234);
    check_one("single_pulse", {31'b0, switch_pulse}, 32'h1);
    check_one("single_owner", {30'b0, owner_id}, 32'h0);
    tick("single2");
    check_one("single_pulse_end", {31'b0, switch_pulse}, 32'h0);

    // Round-robin rotation, each owner exactly DWELL cycles
    reset_dut();
    data_in = {32'd3, 32'd2, 32'd1, 32'd0};
    req = 4'b1111;
    for (int t = 0; t < 20; t++) begin
      tick("rr");
      check_one("rr_owner", {30'b0, owner_id}, 32'((t / 4) % 4));
      check_one("rr_data", disp_data, 32'((t / 4) % 4));
      check_one("rr_pulse", {31'b0, switch_pulse}, 32'(t % 4 == 0));
    end

    // No takeover before dwell expiry, then owner release
    reset_dut();
    req = 4'b0100;
    tick("nopre0");
    tick("nopre1");
    req = 4'b1100;
    tick("nopre2");
    check_one("nopre_owner_c2", {30'b0, owner_id}, 32'd2);
    tick("nopre3");
    check_one("nopre_owner_c3", {30'b0, owner_id}, 32'd2);
    tick("nopre_sw");
    check_one("nopre_sw_grant", {28'b0, grant}, 32'b1000);
    check_one("nopre_sw_pulse", {31'b0, switch_pulse}, 32'h1);
    tick("own3_c1");
    tick("own3_c2");
    req = 4'b0100;
    tick("release");
    check_one("release_grant", {28'b0, grant}, 32'h0);
    check_one("release_data", disp_data, 32'hFFFF_FFFF);
    check_one("release_pulse", {31'b0, switch_pulse}, 32'h1);
    check_one("release_owner_kept", {30'b0, owner_id}, 32'd3);
    tick("regrant");
    check_one("regrant_grant", {28'b0, grant}, 32'b0100);

    // Simultaneous release and dwell expiry
    reset_dut();
    req = 4'b0010;
    tick("sim0");
    tick("sim1");
    req = 4'b0110;
    tick("sim2");
    tick("sim3");
    req = 4'b0100;
    tick("sim_rel");
    check_one("sim_idle_grant", {28'b0, grant}, 32'h0);
    check_one("sim_idle_valid", {31'b0, disp_valid}, 32'h0);
    tick("sim_new");
    check_one("sim_new_grant", {28'b0, grant}, 32'b0100);

    // Sole owner persistence and reset mid-hold
    reset_dut();
    req = 4'b0010;
    tick("sole0");
    for (int t = 0; t < 20; t++) begin
      tick("sole");
      check_one("sole_grant", {28'b0, grant}, 32'b0010);
      check_one("sole_pulse", {31'b0, switch_pulse}, 32'h0);
    end
    reset = 1'b0;
    tick("midrst");
    check_one("midrst_grant", {28'b0, grant}, 32'h0);
    check_one("midrst_data", disp_data, 32'hFFFF_FFFF);
    check_one("midrst_owner", {30'b0, owner_id}, 32'h0);
    check_one("midrst_pulse", {31'b0, switch_pulse}, 32'h0);
    reset = 1'b1;
    tick("postrst");
    check_one("postrst_grant", {28'b0, grant}, 32'b0010);

    // Requester 0 waits out owner 3's dwell (no preemption in default build)
    reset_dut();
    req = 4'b1000;
    tick("pre0");
    tick("pre1");
    req = 4'b1001;
    tick("pre2");
    check_one("pre2_grant", {28'b0, grant}, 32'b1000);
    tick("pre3");
    check_one("pre3_grant", {28'b0, grant}, 32'b1000);
    tick("pre_sw");
    check_one("pre_sw_grant", {28'b0, grant}, 32'b0001);

    // Random traffic against the model
    reset_dut();
    for (int t = 0; t < 600; t++) begin
      reset = ($urandom_range(63) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(3) == 0) req = 4'($urandom);
      data_in[$urandom_range(3)*32 +: 32] = $urandom;
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/display_share_arbiter.md
Name: display_share_arbiter

Overview:
- Round-robin arbiter that shares the 8-digit seven-segment display path among NUM_REQ requesters.
- Each requester presents a 32-bit display word. The arbiter grants one owner at a time and enforces a minimum dwell time so a shown value stays readable.
- It drives the registered word that feeds the display driver's data input.
- It sits between the application blocks (counters, ALU results, status words) and the display driver.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, width of each display word.
- DWELL_CYCLES, 50_000_000, minimum clock cycles an owner keeps the display while others wait (>=2).
- BLANK_WORD, 32'hFFFF_FFFF, word output when no owner exists. Nibbles A–F decode to all segments off, so the display goes dark.

Ports:
- clock  in  1  system clock, all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- req  in  NUM_REQ  per-requester level request; bit i belongs to requester i.
- data_in  in  NUM_REQ*DATA_W  requester i word at bits [i*DATA_W +: DATA_W].
- grant  out  NUM_REQ  one-hot (or zero) current owner.
- disp_data  out  DATA_W  registered word for the display driver.
- disp_valid  out  1  high while an owner holds the display.
- owner_id  out  $clog2(NUM_REQ)  index of current/last owner.
- switch_pulse  out  1  one-cycle pulse on every ownership change, including release to idle.

Behaviour:
- Reset state: reset sampled low at a rising edge sets:
  - state=IDLE, grant=0, disp_data=BLANK_WORD, disp_valid=0, owner_id=0;
  - switch_pulse=0, dwell counter=0, round-robin pointer=NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-hold aborts the hold immediately; no pulse is emitted.
- States: IDLE, HOLD.
- IDLE:
  - If any req is set, grant the first set bit searching upward from pointer+1 with wrap-around.
  - On that edge: grant, owner_id and pointer update; switch_pulse=1; dwell counter=0; go to HOLD.
  - If no req is set, stay in IDLE.
- HOLD:
  - The dwell counter increments each cycle and saturates at DWELL_CYCLES-1.
  - If req[owner] drops: go to IDLE next edge with grant=0, disp_valid=0, switch_pulse=1, disp_data=BLANK_WORD. No direct hand-off in the same cycle; the new grant occurs one cycle later from IDLE.
  - If the counter has saturated and another req bit is set: grant the next requester in round-robin order (search from owner+1, skipping owner). Reset the counter and pulse switch_pulse. Stay in HOLD.
  - If the counter has saturated and no other requester is waiting: the owner keeps the display indefinitely; the counter stays saturated.
  - Simultaneous owner release and dwell expiry: release takes precedence; go to IDLE.
- Datapath:
  - disp_data is the owner's data_in slice, registered: a change on the owner's data_in appears on disp_data one cycle later.
  - On a grant edge, disp_data loads the new owner's word on the same edge. Latency from req high in IDLE to valid data is 1 cycle.
- Invariants:
  - grant is never multi-hot.
  - grant is all-zero iff disp_valid=0.
  - owner_id holds its last value when idle.
- Request bits for out-of-range indices do not exist; DATA_W<32 words are zero-extended by the driver, not here.

Optional Feature:
- Macro: DISP_ARB_PREEMPT0_EN.
- Defined: requester 0 is urgent. If req[0] rises while another owner holds, requester 0 is granted on the next edge regardless of dwell count (counter reset, switch_pulse=1). While requester 0 owns, no one else can take over on dwell expiry until req[0] drops. The round-robin pointer is set to 0 as for a normal grant.
- Undefined: requester 0 is arbitrated identically to the others. No preemption logic is synthesized.

Test Plan:
- Reset and single requester: DWELL_CYCLES=4. Hold reset low 3 cycles, then release; check grant=0, disp_data=FFFF_FFFF, disp_valid=0. Raise req=0001 with data0=0000_1234; one cycle later expect grant=0001, disp_data=0000_1234, switch_pulse for 1 cycle, owner_id=0.
- Round-robin rotation: req=1111 held with data_i=i. Expect owners 0→1→2→3→0, each held exactly 4 cycles, with one switch_pulse per change. disp_data follows 0,1,2,3,0.
- Owner release and no-preempt before dwell: owner 2 granted; req[3] rises at dwell count 1. Owner 2 must keep the display until count saturates, then switch to 3. Next, drop req[3] at count 2: expect IDLE, disp_data=FFFF_FFFF, and a pulse.
- Simultaneous release and expiry: owner 1 drops req on the saturating cycle while req[2] is high. Expect IDLE for 1 cycle, then grant=0100.
- Sole owner persistence and reset mid-hold: req=0010 alone for 20 cycles gives continuous grant with no pulses. Assert reset for 1 cycle mid-hold: outputs return to reset values. After reset, req=0010 is still high, so grant returns on the next edge.
- Preemption (DISP_ARB_PREEMPT0_EN defined): owner 3 at count 1; raise req[0]. Expect grant=0001 on the next edge. With the macro undefined, the same stimulus gives grant=0001 only after owner 3's 4-cycle dwell.
